ball_motion_ctrl: RTL and testbench
===================================

// Module: ball_motion_ctrl
// PURPOSE
//  Frame-rate scheduler for the ball-position update datapath: once per frame tick it pulses Compute_alter,
//  takes the updated location one cycle later, resolves wall/paddle collisions and misses, and writes back
//  the corrected location, velocity and angle that feed the datapath on the next frame.
//  Sits between the VGA frame timing, the paddle (motion-sensor) positions and the position-update datapath.
// PARAMETERS
//  X_MIN 11'd8 / X_MAX 11'd631 : paddle lines (left player A, right player B)
//  Y_MIN 11'd8 / Y_MAX 11'd471 : top/bottom walls
//  PADDLE_HALF 11'd32 : half paddle height; hit when |ball_y - paddle_y| <= PADDLE_HALF
//  INIT_X 11'd395 / INIT_Y 11'd240 : serve location
//  VX_INIT 11'd2 / VY_INIT 11'd1 : serve speed magnitudes (pixels per frame)
//  SERVE_FRAMES 8'd60 : frame ticks the ball is held at the serve point after a miss
//  VX_MAX 11'd8 : x speed ceiling (used only with BALL_SPEEDUP_EN)
// PORTS
//  clk  in 1 : system clock
//  rst_n  in 1 : synchronous reset, ACTIVE-HIGH (name kept, polarity is high)
//  frame_tick  in 1 : one-cycle pulse per VGA frame
//  game_en  in 1 : 0 = freeze; ticks ignored
//  paddle_a_y / paddle_b_y  in 11 : paddle centre rows
//  new_ball_location  in 22 : datapath result {x[21:11], y[10:0]}
//  compute_alter  out 1 : datapath update strobe
//  ball_location  out 22 : committed location, fed to datapath
//  ball_velocity  out 32 : [30:20] |vx|, [15] vy sign (1 = y decreasing), [14:4] |vy|, other bits 0
//  ball_angle  out 17 : [16] x direction (1 = x decreasing, toward A), [15:0] 0
//  score_a / score_b  out 1 : one-cycle point pulses
//  step_done  out 1 : one-cycle pulse after each commit
//  overrun  out 1 : sticky; frame_tick arrived while not IDLE/SERVE
// BEHAVIOUR
//  Reset: state IDLE; compute_alter/score_*/step_done/overrun 0; ball_location {INIT_X,INIT_Y};
//   velocity |vx|=VX_INIT, [15]=0, |vy|=VY_INIT; ball_angle[16]=1. Reset in any state aborts at the next edge.
//  States: IDLE -> STEP -> CHECK -> IDLE | SERVE; SERVE -> IDLE.
//  IDLE: frame_tick & game_en -> STEP. STEP: compute_alter=1 (Moore, exactly one cycle).
//  CHECK: new_ball_location valid (datapath registered at end of STEP); classify, commit at the CHECK->next edge;
//   step_done=1 the cycle after. Latency tick(cycle 0) -> compute_alter(cycle 1) -> outputs updated(cycle 3).
//  Classification on nx,ny (11-bit unsigned, datapath wraps):
//   Y: vy decreasing & (ny<Y_MIN | ny>Y_MAX) -> ny=Y_MIN, [15]=0; vy increasing & ny>Y_MAX -> ny=Y_MAX, [15]=1.
//   X left (angle[16]=1) & (nx<X_MIN | nx>X_MAX): hit A -> nx=X_MIN, angle[16]=0; miss -> score_b, SERVE.
//   X right (angle[16]=0) & nx>X_MAX: hit B -> nx=X_MAX, angle[16]=1; miss -> score_a, SERVE.
//   Hit test uses the Y-corrected ny. Corner (Y and X event same step): apply both, Y first.
//   No event: commit {nx,ny} unchanged.
//  Miss: ball_location={INIT_X,INIT_Y}, |vx|=VX_INIT, |vy|=VY_INIT, angle[16] points toward the scorer's
//   opponent's loser side reversed (serve toward player who lost), score pulse in the commit cycle+1 with step_done.
//  SERVE: count SERVE_FRAMES frame_ticks (game_en high), then IDLE; no compute_alter issued.
//  game_en low: IDLE/SERVE counter frozen; STEP/CHECK still complete.
//  frame_tick in STEP/CHECK: dropped, overrun<=1 (cleared only by reset).
// CONFIGURATION
//  BALL_SPEEDUP_EN defined: each paddle hit sets |vx|=min(|vx|+1, VX_MAX). Undefined: |vx| changes only on serve.
// STRUCTURE
//  pingpong_pkg: location/velocity field slice constants, state enum, collision-class enum {NONE,WALL,HIT,MISS}.
//  Sub-module ball_bounds_check: combinational classification + corrected nx/ny/direction; FSM and registers here.
// TESTING
//  Reset, one tick at {395,240}, vx=2 left, vy=1 down, datapath model -> compute_alter 1 cycle, loc {393,241} at cycle 3.
//  loc y=9, vy up 2 -> ny=7 clamped to 8, [15]=0, x advances normally.
//  ball x=9 moving left, paddle_a_y=ball_y+32 -> x=8, angle[16]=0, no score; y+33 -> score_b, loc {395,240}, SERVE.
//  x=2 moving left vx=4 (wraps to 2046) -> treated as crossing A line, hit/miss as above.
//  In SERVE, 59 ticks -> no compute_alter; 60th -> IDLE; next tick -> STEP. Tick during STEP -> overrun=1.
//  BALL_SPEEDUP_EN: 7 consecutive hits from vx=2 -> vx saturates at 8; without macro vx stays 2.

Source files
------------

// File: rtl/pingpong_pkg.sv
// pingpong_pkg: shared constants, field slice positions and enums for the
// ball motion controller and its bounds checker.
// Optional feature macro: BALL_SPEEDUP_EN (adds the VX_MAX ceiling constant).
package pingpong_pkg;

    // Bus widths
    localparam int unsigned COORD_W = 11;
    localparam int unsigned LOC_W   = 2 * COORD_W;
    localparam int unsigned VEL_W   = 32;
    localparam int unsigned ANG_W   = 17;
    localparam int unsigned CNT_W   = 8;

    // Field positions inside the location / velocity / angle buses
    localparam int unsigned LOC_X_LSB   = 11;
    localparam int unsigned LOC_Y_LSB   = 0;
    localparam int unsigned VEL_VX_LSB  = 20;
    localparam int unsigned VEL_VY_SIGN = 15;
    localparam int unsigned VEL_VY_LSB  = 4;
    localparam int unsigned ANG_DIR     = 16;

    // Playfield geometry
    localparam logic [COORD_W-1:0] X_MIN       = 11'd8;
    localparam logic [COORD_W-1:0] X_MAX       = 11'd631;
    localparam logic [COORD_W-1:0] Y_MIN       = 11'd8;
    localparam logic [COORD_W-1:0] Y_MAX       = 11'd471;
    localparam logic [COORD_W-1:0] PADDLE_HALF = 11'd32;

    // Serve point, serve speed and serve hold time
    localparam logic [COORD_W-1:0] INIT_X       = 11'd395;
    localparam logic [COORD_W-1:0] INIT_Y       = 11'd240;
    localparam logic [COORD_W-1:0] VX_INIT      = 11'd2;
    localparam logic [COORD_W-1:0] VY_INIT      = 11'd1;
    localparam logic [CNT_W-1:0]   SERVE_FRAMES = 8'd60;

`ifdef BALL_SPEEDUP_EN
    // x speed ceiling for paddle-hit acceleration
    localparam logic [COORD_W-1:0] VX_MAX = 11'd8;
`endif

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_STEP  = 2'd1,
        ST_CHECK = 2'd2,
        ST_SERVE = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        COL_NONE = 2'd0,
        COL_WALL = 2'd1,
        COL_HIT  = 2'd2,
        COL_MISS = 2'd3
    } col_t;

    // Unsigned distance between two rows
    function automatic logic [COORD_W-1:0] abs_diff(input logic [COORD_W-1:0] a,
                                                    input logic [COORD_W-1:0] b);
        return (a >= b) ? (a - b) : (b - a);
    endfunction

endpackage

// File: rtl/ball_bounds_check.sv
// ball_bounds_check: combinational collision classifier for one frame step.
// Takes the datapath's raw next location and the current directions, resolves
// wall bounces first, then the paddle line on the side the ball is heading to.
// Ports:
//   nx, ny              in  : raw next location from the datapath (11-bit, wrapping)
//   vy_up, dir_left     in  : current y direction (1 = y decreasing), x direction (1 = toward A)
//   paddle_a_y/_b_y     in  : paddle centre rows
//   cx_c, cy_c          out : corrected location
//   vy_up_c, dir_left_c out : corrected directions
//   col_c               out : collision class (col_t encoding)
//   miss_a_c            out : the miss (if any) was on player A's side
module ball_bounds_check
    import pingpong_pkg::*;
(
    input  logic [COORD_W-1:0] nx,
    input  logic [COORD_W-1:0] ny,
    input  logic               vy_up,
    input  logic               dir_left,
    input  logic [COORD_W-1:0] paddle_a_y,
    input  logic [COORD_W-1:0] paddle_b_y,
    output logic [COORD_W-1:0] cx_c,
    output logic [COORD_W-1:0] cy_c,
    output logic               vy_up_c,
    output logic               dir_left_c,
    output logic [1:0]         col_c,
    output logic               miss_a_c
);

    col_t col;

    // Y wall is resolved first so the paddle test sees the clamped row.
    // A ball moving left that wraps below zero lands above X_MAX, hence the
    // two-sided test on the A line.
    always_comb begin
        cx_c       = nx;
        cy_c       = ny;
        vy_up_c    = vy_up;
        dir_left_c = dir_left;
        col        = COL_NONE;
        miss_a_c   = 1'b0;

        if (vy_up && ((ny < Y_MIN) || (ny > Y_MAX))) begin
            cy_c    = Y_MIN;
            vy_up_c = 1'b0;
            col     = COL_WALL;
        end else if (!vy_up && (ny > Y_MAX)) begin
            cy_c    = Y_MAX;
            vy_up_c = 1'b1;
            col     = COL_WALL;
        end

        if (dir_left && ((nx < X_MIN) || (nx > X_MAX))) begin
            if (abs_diff(cy_c, paddle_a_y) <= PADDLE_HALF) begin
                cx_c       = X_MIN;
                dir_left_c = 1'b0;
                col        = COL_HIT;
            end else begin
                col      = COL_MISS;
                miss_a_c = 1'b1;
            end
        end else if (!dir_left && (nx > X_MAX)) begin
            if (abs_diff(cy_c, paddle_b_y) <= PADDLE_HALF) begin
                cx_c       = X_MAX;
                dir_left_c = 1'b1;
                col        = COL_HIT;
            end else begin
                col = COL_MISS;
            end
        end
    end

    assign col_c = col;

endmodule

// File: rtl/ball_motion_ctrl.sv
// ball_motion_ctrl: per-frame scheduler for the ball position update.
// On each accepted frame tick it strobes the datapath, takes the updated
// location one cycle later, resolves collisions/misses and commits the new
// location, velocity and direction. After a miss the ball is held at the
// serve point for SERVE_FRAMES frames.
// Optional feature macro: BALL_SPEEDUP_EN (paddle hits raise |vx| up to VX_MAX).
// Ports:
//   clk, rst_n          in  : clock, synchronous reset (active HIGH despite the name)
//   frame_tick          in  : one-cycle pulse per video frame
//   game_en             in  : 0 freezes the game (ticks ignored in IDLE/SERVE)
//   paddle_a_y/_b_y     in  : paddle centre rows
//   new_ball_location   in  : datapath result {x, y}
//   compute_alter       out : datapath update strobe
//   ball_location       out : committed location {x, y}
//   ball_velocity       out : {|vx| @30:20, vy sign @15, |vy| @14:4}
//   ball_angle          out : x direction @16 (1 = toward A)
//   score_a, score_b    out : one-cycle point pulses
//   step_done           out : one-cycle pulse after each commit
//   overrun             out : sticky, tick seen while a step was in flight
module ball_motion_ctrl
    import pingpong_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               frame_tick,
    input  logic               game_en,
    input  logic [COORD_W-1:0] paddle_a_y,
    input  logic [COORD_W-1:0] paddle_b_y,
    input  logic [LOC_W-1:0]   new_ball_location,
    output logic               compute_alter,
    output logic [LOC_W-1:0]   ball_location,
    output logic [VEL_W-1:0]   ball_velocity,
    output logic [ANG_W-1:0]   ball_angle,
    output logic               score_a,
    output logic               score_b,
    output logic               step_done,
    output logic               overrun
);

    state_t             state, state_nx;
    logic [CNT_W-1:0]   serve_cnt, serve_cnt_nx;
    logic [COORD_W-1:0] loc_x, loc_x_nx;
    logic [COORD_W-1:0] loc_y, loc_y_nx;
    logic [COORD_W-1:0] vx, vx_nx;
    logic [COORD_W-1:0] vy, vy_nx;
    logic               vy_up, vy_up_nx;
    logic               dir_left, dir_left_nx;
    logic               compute_alter_nx;
    logic               score_a_nx, score_b_nx;
    logic               step_done_nx;
    logic               overrun_nx;

    logic [COORD_W-1:0] cx_c, cy_c;
    logic               vy_up_c, dir_left_c, miss_a_c;
    logic [1:0]         col_raw;
    col_t               col;

    // Collision classification of the datapath result
    ball_bounds_check u_bounds (
        .nx         (new_ball_location[LOC_X_LSB +: COORD_W]),
        .ny         (new_ball_location[LOC_Y_LSB +: COORD_W]),
        .vy_up      (vy_up),
        .dir_left   (dir_left),
        .paddle_a_y (paddle_a_y),
        .paddle_b_y (paddle_b_y),
        .cx_c       (cx_c),
        .cy_c       (cy_c),
        .vy_up_c    (vy_up_c),
        .dir_left_c (dir_left_c),
        .col_c      (col_raw),
        .miss_a_c   (miss_a_c)
    );

    assign col = col_t'(col_raw);

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst_n) begin
            state         <= ST_IDLE;
            serve_cnt     <= '0;
            loc_x         <= INIT_X;
            loc_y         <= INIT_Y;
            vx            <= VX_INIT;
            vy            <= VY_INIT;
            vy_up         <= 1'b0;
            dir_left      <= 1'b1;
            compute_alter <= 1'b0;
            score_a       <= 1'b0;
            score_b       <= 1'b0;
            step_done     <= 1'b0;
            overrun       <= 1'b0;
        end else begin
            state         <= state_nx;
            serve_cnt     <= serve_cnt_nx;
            loc_x         <= loc_x_nx;
            loc_y         <= loc_y_nx;
            vx            <= vx_nx;
            vy            <= vy_nx;
            vy_up         <= vy_up_nx;
            dir_left      <= dir_left_nx;
            compute_alter <= compute_alter_nx;
            score_a       <= score_a_nx;
            score_b       <= score_b_nx;
            step_done     <= step_done_nx;
            overrun       <= overrun_nx;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_nx         = state;
        serve_cnt_nx     = serve_cnt;
        loc_x_nx         = loc_x;
        loc_y_nx         = loc_y;
        vx_nx            = vx;
        vy_nx            = vy;
        vy_up_nx         = vy_up;
        dir_left_nx      = dir_left;
        compute_alter_nx = 1'b0;
        score_a_nx       = 1'b0;
        score_b_nx       = 1'b0;
        step_done_nx     = 1'b0;
        overrun_nx       = overrun;

        case (state)
            ST_IDLE: begin
                // compute_alter is raised for exactly the STEP cycle
                if (frame_tick && game_en) begin
                    state_nx         = ST_STEP;
                    compute_alter_nx = 1'b1;
                end
            end

            ST_STEP: begin
                state_nx = ST_CHECK;
            end

            ST_CHECK: begin
                step_done_nx = 1'b1;
                if (col == COL_MISS) begin
                    // Re-serve from the centre toward the player who missed
                    state_nx     = ST_SERVE;
                    serve_cnt_nx = '0;
                    loc_x_nx     = INIT_X;
                    loc_y_nx     = INIT_Y;
                    vx_nx        = VX_INIT;
                    vy_nx        = VY_INIT;
                    vy_up_nx     = 1'b0;
                    dir_left_nx  = miss_a_c;
                    score_b_nx   = miss_a_c;
                    score_a_nx   = !miss_a_c;
                end else begin
                    state_nx    = ST_IDLE;
                    loc_x_nx    = cx_c;
                    loc_y_nx    = cy_c;
                    vy_up_nx    = vy_up_c;
                    dir_left_nx = dir_left_c;
`ifdef BALL_SPEEDUP_EN
                    if (col == COL_HIT) begin
                        vx_nx = (vx >= VX_MAX) ? VX_MAX : (vx + COORD_W'(1));
                    end
`endif
                end
            end

            ST_SERVE: begin
                // Hold the ball until SERVE_FRAMES enabled ticks have passed
                if (frame_tick && game_en) begin
                    if (serve_cnt == (SERVE_FRAMES - CNT_W'(1))) begin
                        state_nx     = ST_IDLE;
                        serve_cnt_nx = '0;
                    end else begin
                        serve_cnt_nx = serve_cnt + CNT_W'(1);
                    end
                end
            end

            default: begin
                state_nx = ST_IDLE;
            end
        endcase

        // A tick while a step is in flight is dropped and flagged
        if (frame_tick && ((state == ST_STEP) || (state == ST_CHECK))) begin
            overrun_nx = 1'b1;
        end
    end

    // Output bus assembly from the committed registers
    assign ball_location = {loc_x, loc_y};

    always_comb begin
        ball_velocity                           = '0;
        ball_velocity[VEL_VX_LSB +: COORD_W]    = vx;
        ball_velocity[VEL_VY_SIGN]              = vy_up;
        ball_velocity[VEL_VY_LSB +: COORD_W]    = vy;
    end

    always_comb begin
        ball_angle          = '0;
        ball_angle[ANG_DIR] = dir_left;
    end

endmodule

// File: tb/tb_ball_motion_ctrl.sv
// tb_ball_motion_ctrl: randomized self-checking bench for ball_motion_ctrl.
// A transaction-level model of the ball (position, speeds, directions,
// overrun flag) plus expected pulse flags is compared against every output
// on every falling clock edge; a few literal expectations pin the model.
module tb_ball_motion_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        frame_tick;
    logic        game_en;
    logic [10:0] paddle_a_y;
    logic [10:0] paddle_b_y;
    logic [21:0] new_ball_location;
    logic        compute_alter;
    logic [21:0] ball_location;
    logic [31:0] ball_velocity;
    logic [16:0] ball_angle;
    logic        score_a;
    logic        score_b;
    logic        step_done;
    logic        overrun;

    ball_motion_ctrl dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .frame_tick        (frame_tick),
        .game_en           (game_en),
        .paddle_a_y        (paddle_a_y),
        .paddle_b_y        (paddle_b_y),
        .new_ball_location (new_ball_location),
        .compute_alter     (compute_alter),
        .ball_location     (ball_location),
        .ball_velocity     (ball_velocity),
        .ball_angle        (ball_angle),
        .score_a           (score_a),
        .score_b           (score_b),
        .step_done         (step_done),
        .overrun           (overrun)
    );

    always #5 clk = ~clk;

    // Ball model
    int m_x, m_y, m_vx, m_vy;
    bit m_up, m_left, m_ovr;
    int m_hits = 0;
    // Expected one-cycle pulses
    bit e_ca, e_done, e_sa, e_sb;
    bit chk_en;
    bit missed;
    int n_checks = 0;
    int n_fail   = 0;
    // Literal pin requests handed to the compare process
    int          lit_seq  = 0;
    int          lit_seen = 0;
    int          lit_sel;
    logic [31:0] lit_val;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Compare process: all outputs against the model on every cycle
    always @(negedge clk) begin
        if (chk_en) begin
            check("compute_alter", 32'(compute_alter), 32'(e_ca));
            check("ball_location", 32'(ball_location), 32'(m_x * 2048 + m_y));
            check("ball_velocity", 32'(ball_velocity),
                  32'(m_vx * (1 << 20) + int'(m_up) * (1 << 15) + m_vy * 16));
            check("ball_angle", 32'(ball_angle), 32'(int'(m_left) * 65536));
            check("score_a", 32'(score_a), 32'(e_sa));
            check("score_b", 32'(score_b), 32'(e_sb));
            check("step_done", 32'(step_done), 32'(e_done));
            check("overrun", 32'(overrun), 32'(m_ovr));
            if (lit_seq != lit_seen) begin
                case (lit_sel)
                    0:       check("pin_location", 32'(ball_location), lit_val);
                    1:       check("pin_velocity", ball_velocity, lit_val);
                    2:       check("pin_angle", 32'(ball_angle), lit_val);
                    3:       check("pin_overrun", 32'(overrun), lit_val);
                    default: check("pin_vx", 32'(ball_velocity[30:20]), lit_val);
                endcase
                lit_seen = lit_seq;
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_x = 395; m_y = 240; m_vx = 2; m_vy = 1;
        m_up = 1'b0; m_left = 1'b1; m_ovr = 1'b0;
        e_ca = 1'b0; e_done = 1'b0; e_sa = 1'b0; e_sb = 1'b0;
    endtask

    task automatic pin(input int sel, input logic [31:0] val);
        lit_sel = sel;
        lit_val = val;
        lit_seq++;
        cyc();
    endtask

    // Datapath arithmetic: next position from the committed state
    function automatic int dp_x();
        return (m_x + (m_left ? 2048 - m_vx : m_vx)) % 2048;
    endfunction

    function automatic int dp_y();
        return (m_y + (m_up ? 2048 - m_vy : m_vy)) % 2048;
    endfunction

    // Apply the game rules to a raw datapath result
    task automatic model_commit(input int nx, input int ny, input int pa, input int pb,
                                output bit sa, output bit sb);
        int  x, y, d;
        bit  up, left, hit;
        x = nx; y = ny; up = m_up; left = m_left; hit = 1'b0;
        sa = 1'b0; sb = 1'b0;
        if (m_up && (ny < 8 || ny > 471)) begin
            y = 8; up = 1'b0;
        end else if (!m_up && ny > 471) begin
            y = 471; up = 1'b1;
        end
        if (m_left && (nx < 8 || nx > 631)) begin
            d = (y > pa) ? y - pa : pa - y;
            if (d <= 32) begin x = 8; left = 1'b0; hit = 1'b1; end
            else sb = 1'b1;
        end else if (!m_left && nx > 631) begin
            d = (y > pb) ? y - pb : pb - y;
            if (d <= 32) begin x = 631; left = 1'b1; hit = 1'b1; end
            else sa = 1'b1;
        end
        if (sa || sb) begin
            m_x = 395; m_y = 240; m_vx = 2; m_vy = 1; m_up = 1'b0; m_left = sb;
        end else begin
            m_x = x; m_y = y; m_up = up; m_left = left;
            if (hit) begin
                m_hits++;
`ifdef BALL_SPEEDUP_EN
                m_vx = (m_vx + 1 > 8) ? 8 : m_vx + 1;
`endif
            end
        end
    endtask

    // One frame step: tick, strobe, datapath result, commit.
    // ovr_mode 1/2 adds a stray tick during STEP/CHECK.
    task automatic do_step(input int nx, input int ny, input int pa, input int pb,
                           input int ovr_mode, output bit was_miss);
        bit sa, sb;
        frame_tick = 1'b1; game_en = 1'b1;
        cyc();
        frame_tick = (ovr_mode == 1); game_en = 1'($urandom % 2); e_ca = 1'b1;
        new_ball_location = {11'(nx), 11'(ny)};
        paddle_a_y = 11'(pa); paddle_b_y = 11'(pb);
        cyc();
        e_ca = 1'b0;
        if (ovr_mode == 1) m_ovr = 1'b1;
        frame_tick = (ovr_mode == 2); game_en = 1'($urandom % 2);
        cyc();
        if (ovr_mode == 2) m_ovr = 1'b1;
        frame_tick = 1'b0; game_en = 1'b1;
        model_commit(nx, ny, pa, pb, sa, sb);
        e_done = 1'b1; e_sa = sa; e_sb = sb;
        cyc();
        e_done = 1'b0; e_sa = 1'b0; e_sb = 1'b0;
        was_miss = sa | sb;
    endtask

    // Ticks with game_en low must be ignored
    task automatic idle_noise();
        frame_tick = 1'b1; game_en = 1'b0;
        cyc();
        frame_tick = 1'b0; game_en = 1'b1;
        cyc();
    endtask

    // Feed enabled ticks until the serve hold of 60 frames has elapsed
    task automatic serve_wait();
        int counted;
        counted = 0;
        while (counted < 60) begin
            if ($urandom % 3 == 0) cyc();
            frame_tick = 1'b1;
            game_en = ($urandom % 4 != 0);
            if (game_en) counted++;
            cyc();
            frame_tick = 1'b0; game_en = 1'b1;
        end
    endtask

    function automatic int pick_x();
        case ($urandom % 4)
            0:       return dp_x();
            1:       return ($urandom % 2 == 1) ? int'($urandom % 16) : 2040 + int'($urandom % 8);
            2:       return 620 + int'($urandom % 31);
            default: return int'($urandom % 2048);
        endcase
    endfunction

    function automatic int pick_y();
        case ($urandom % 4)
            0:       return dp_y();
            1:       return int'($urandom % 16);
            2:       return 460 + int'($urandom % 21);
            default: return int'($urandom % 2048);
        endcase
    endfunction

    function automatic int pick_pad(input int ny);
        int base, off;
        base = ny;
        if ((ny > 471 || ny < 8) && ($urandom % 2 == 1)) base = ($urandom % 2 == 1) ? 8 : 471;
        case ($urandom % 4)
            0: return int'($urandom % 2048);
            1: begin
                off = ($urandom % 2 == 1) ? 32 : 33;
                if ($urandom % 2 == 1) off = -off;
                return (base + off + 2048) % 2048;
            end
            default: return (base + int'($urandom % 61) - 30 + 2048) % 2048;
        endcase
    endfunction

    initial begin
        int nx, ny, r, om;
        rst_n = 1'b1; frame_tick = 1'b0; game_en = 1'b1;
        paddle_a_y = 11'd240; paddle_b_y = 11'd240; new_ball_location = '0;
        model_reset();
        chk_en = 1'b0;
        cyc();
        chk_en = 1'b1;
        cyc();
        rst_n = 1'b0;
        cyc();

        // Reset values
        pin(0, {10'b0, 11'd395, 11'd240});
        pin(1, 32'h0020_0010);
        pin(2, 32'h0001_0000);
        pin(3, 32'h0);

        // First step from the serve point through the datapath arithmetic
        do_step(dp_x(), dp_y(), 240, 240, 0, missed);
        pin(0, {10'b0, 11'd393, 11'd241});
        idle_noise();

        // Bottom wall, then top wall with wrap-free undershoot
        do_step(dp_x(), 480, 240, 240, 0, missed);
        pin(1, 32'h0020_8010);
        do_step(dp_x(), 7, 240, 240, 0, missed);
        pin(0, {10'b0, 11'd389, 11'd8});
        pin(1, 32'h0020_0010);

        // Paddle A hit at the edge of the paddle, paddle B hit, then A miss by one row
        do_step(7, 100, 132, 0, 0, missed);
        pin(0, {10'b0, 11'd8, 11'd100});
        pin(2, 32'h0);
        do_step(640, 100, 0, 68, 0, missed);
        pin(2, 32'h0001_0000);
        do_step(7, 100, 133, 0, 1, missed);
        pin(0, {10'b0, 11'd395, 11'd240});
        pin(2, 32'h0001_0000);
        pin(3, 32'h1);
        serve_wait();

        // Wrapped x below zero counts as crossing the A line; then a rally of hits
        do_step(2046, 240, 240, 0, 0, missed);
        pin(0, {10'b0, 11'd8, 11'd240});
        for (int i = 0; i < 6; i++) begin
            if (m_left) do_step(2046, 200, 200, 0, 0, missed);
            else        do_step(700, 200, 0, 200, 0, missed);
        end
`ifdef BALL_SPEEDUP_EN
        pin(4, 32'd8);
`else
        pin(4, 32'd2);
`endif

        // Randomized play
        for (int i = 0; i < 300; i++) begin
            if ($urandom % 8 == 0) idle_noise();
            nx = pick_x();
            ny = pick_y();
            r  = int'($urandom % 8);
            om = (r == 0) ? 1 : ((r == 1) ? 2 : 0);
            do_step(nx, ny, pick_pad(ny), pick_pad(ny), om, missed);
            if (missed) serve_wait();
        end

        // Reset in the middle of a step aborts it
        frame_tick = 1'b1; game_en = 1'b1;
        cyc();
        frame_tick = 1'b0; e_ca = 1'b1; rst_n = 1'b1;
        cyc();
        model_reset();
        rst_n = 1'b0;
        cyc();
        pin(3, 32'h0);
        pin(0, {10'b0, 11'd395, 11'd240});
        do_step(dp_x(), dp_y(), 240, 240, 0, missed);
        pin(0, {10'b0, 11'd393, 11'd241});

        $display("paddle hits modelled: %0d", m_hits);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
